// File: rtl/pipe_skid_reg_pkg.sv
// Shared types for the inter-stage pipeline registers: stage payload structs,
// their widths and the all-zero NOP bubbles that a clearing flush produces.
package pipe_skid_reg_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned OCC_W    = 2;

  // LSU_NONE must stay at zero so that a zeroed payload is a legal bubble
  typedef enum logic [1:0] {
    LSU_NONE  = 2'd0,
    LSU_LOAD  = 2'd1,
    LSU_STORE = 2'd2
  } lsu_op_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } if_id_pkt_t;

  typedef struct packed {
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     rs1_val;
    logic [XLEN-1:0]     rs2_val;
    logic [XLEN-1:0]     imm;
    logic [REG_AW-1:0]   rd;
    logic [ALU_OP_W-1:0] alu_op;
    lsu_op_e             lsu_op;
    logic                reg_we;
  } id_ex_pkt_t;

  typedef struct packed {
    logic [XLEN-1:0]   alu_res;
    logic [XLEN-1:0]   store_data;
    logic [REG_AW-1:0] rd;
    lsu_op_e           lsu_op;
    logic              reg_we;
  } ex_mem_pkt_t;

  typedef struct packed {
    logic [XLEN-1:0]   wb_data;
    logic [REG_AW-1:0] rd;
    logic              reg_we;
  } mem_wb_pkt_t;

  localparam int unsigned IF_ID_PKT_W  = $bits(if_id_pkt_t);
  localparam int unsigned ID_EX_PKT_W  = $bits(id_ex_pkt_t);
  localparam int unsigned EX_MEM_PKT_W = $bits(ex_mem_pkt_t);
  localparam int unsigned MEM_WB_PKT_W = $bits(mem_wb_pkt_t);

  localparam if_id_pkt_t  IF_ID_NOP  = '0;
  localparam id_ex_pkt_t  ID_EX_NOP  = '0;
  localparam ex_mem_pkt_t EX_MEM_NOP = '0;
  localparam mem_wb_pkt_t MEM_WB_NOP = '0;

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic valid/ready pipeline-stage register with optional two-entry skid
// buffer (registered in_ready_o) and a flush that injects a bubble.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int unsigned DATA_W         = 64,
  parameter int unsigned SKID           = 1,
  parameter int unsigned CLEAR_ON_FLUSH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [OCC_W-1:0]  occ_o
);

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid_i & in_ready_o;
  assign out_fire = out_valid_o & out_ready_i;

  if (SKID != 0) begin : g_skid

    typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  main_q, main_d;
    logic [DATA_W-1:0]  skid_q, skid_d;
    logic               valid_q, valid_d;
    logic               ready_q, ready_d;
    logic [OCC_W-1:0]   occ_q, occ_d;

    // Next state and payload movement; flush overrides every handshake
    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush_i) begin
        state_d = ST_EMPTY;
        if (CLEAR_ON_FLUSH != 0) begin
          main_d = '0;
          skid_d = '0;
        end
      end else begin
        unique case (state_q)
          ST_EMPTY: begin
            if (in_fire) begin
              main_d  = in_data_i;
              state_d = ST_BUSY;
            end
          end
          ST_BUSY: begin
            if (in_fire && out_fire) begin
              main_d = in_data_i;
            end else if (in_fire) begin
              skid_d  = in_data_i;
              state_d = ST_FULL;
            end else if (out_fire) begin
              state_d = ST_EMPTY;
            end
          end
          ST_FULL: begin
            if (out_fire) begin
              main_d  = skid_q;
              state_d = ST_BUSY;
            end
          end
          default: state_d = ST_EMPTY;
        endcase
      end
    end

    // Handshake outputs decoded from the next state so they leave flops
    always_comb begin
      valid_d = (state_d != ST_EMPTY);
      ready_d = (state_d != ST_FULL);
      unique case (state_d)
        ST_BUSY: occ_d = OCC_W'(1);
        ST_FULL: occ_d = OCC_W'(2);
        default: occ_d = OCC_W'(0);
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= ST_EMPTY;
        main_q  <= '0;
        skid_q  <= '0;
        valid_q <= 1'b0;
        ready_q <= 1'b1;
        occ_q   <= '0;
      end else begin
        state_q <= state_d;
        main_q  <= main_d;
        skid_q  <= skid_d;
        valid_q <= valid_d;
        ready_q <= ready_d;
        occ_q   <= occ_d;
      end
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = valid_q;
    assign out_data_o  = main_q;
    assign occ_o       = occ_q;

  end else begin : g_pass

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] main_q, main_d;

    // Single register: ready passes straight through from downstream
    always_comb begin
      valid_d = valid_q;
      main_d  = main_q;
      if (flush_i) begin
        valid_d = 1'b0;
        if (CLEAR_ON_FLUSH != 0) begin
          main_d = '0;
        end
      end else if (in_fire) begin
        valid_d = 1'b1;
        main_d  = in_data_i;
      end else if (out_fire) begin
        valid_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        main_q  <= '0;
      end else begin
        valid_q <= valid_d;
        main_q  <= main_d;
      end
    end

    assign in_ready_o  = ~valid_q | out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = main_q;
    assign occ_o       = {1'b0, valid_q};

  end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
Generic, parametrised pipeline-stage register with a valid/ready handshake, an optional skid buffer and a flush (bubble-injection) input. It is the successor to the fixed-field EX/MEM register. Each inter-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB) instantiates it, with the stage payload packed into a single vector. Back-pressure from a stalled downstream stage is absorbed without a combinational ready path through the stage.

Parameters:
DATA_W, 64, payload width in bits (≥1).
SKID, 1, 1 = two-entry skid buffer with registered-state in_ready_o; 0 = single register with pass-through ready.
CLEAR_ON_FLUSH, 1, 1 = flush zeroes all held payload; 0 = flush clears valid only and payload holds its value.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  reset, asynchronous, active-low.
flush_i  in  1  synchronous flush; discards all held entries and any beat presented this cycle.
in_valid_i  in  1  upstream beat valid.
in_ready_o  out  1  stage can accept a beat.
in_data_i  in  DATA_W  upstream payload.
out_valid_o  out  1  downstream beat valid.
out_ready_i  in  1  downstream accepts.
out_data_o  out  DATA_W  downstream payload; always driven from the main register.
occ_o  out  2  entries held (0..2; max 1 when SKID=0).

Behaviour:
- in_fire = in_valid_i & in_ready_o.
- out_fire = out_valid_o & out_ready_i.
- Reset (rst_n=0, asynchronous): state EMPTY, out_valid_o=0, out_data_o=0, skid register=0, occ_o=0, in_ready_o=1.
- Latency: an accepted beat appears on out_data_o the cycle after in_fire when the stage is empty or draining. No combinational path from in_* to out_*.
- Ordering: strict FIFO order; no beat is dropped or duplicated except on flush.
- SKID=1 state machine (in_ready_o = state != FULL, decoded from flops only):
  - EMPTY: on in_fire, main ← in, go to BUSY.
  - BUSY:
    - in_fire & out_fire: main ← in, stay BUSY.
    - in_fire & !out_fire: skid ← in, go to FULL.
    - !in_fire & out_fire: go to EMPTY.
    - Otherwise hold.
  - FULL: in_ready_o=0. On out_fire, main ← skid, go to BUSY. Otherwise hold both registers.
  - out_valid_o = state != EMPTY. occ_o = 0/1/2 for EMPTY/BUSY/FULL.
- SKID=0 mode:
  - in_ready_o = !out_valid_o | out_ready_i (combinational).
  - On in_fire, main ← in and out_valid_o ← 1.
  - On out_fire without in_fire, out_valid_o ← 0.
  - Skid register is not instantiated.
- Flush (flush_i=1) takes priority over every handshake event in the same cycle:
  - Next state EMPTY, out_valid_o ← 0, occ_o ← 0.
  - An in_fire in the flush cycle is discarded.
  - An out_fire in the flush cycle still completes downstream: the beat was presented this cycle and the downstream stage owns it.
  - If CLEAR_ON_FLUSH=1, main and skid ← 0, so the output is a NOP bubble.
  - in_ready_o is 1 in the cycle after the flush.
- Flush held for several cycles: the stage remains EMPTY throughout and accepts nothing.
- Reset asserted mid-transfer: all state is lost immediately. The first beat after reset release is accepted normally.
- Payload is treated as opaque bits: no arithmetic, no width conversion.

Decomposition:
- riscv_pkg gains packed stage-payload structs: if_id_pkt_t, id_ex_pkt_t, ex_mem_pkt_t, mem_wb_pkt_t.
- Each struct has a matching width constant (e.g. EX_MEM_PKT_W) and a NOP constant. The NOP constant equals all-zeros, with lsu_op = LSU_NONE encoded as 0, so CLEAR_ON_FLUSH yields a legal bubble.
- Single module, no sub-module.
- The EMPTY/BUSY/FULL state encoding is a local enum inside the module, not a package type.

Test Plan:
- Streaming, out_ready_i=1 (SKID=1, DATA_W=64): 0x11, 0x22, 0x33 on consecutive cycles → same values on out_data_o one cycle later each, occ_o=1 throughout, in_ready_o never drops.
- Back-pressure: out_ready_i=0, send 0xA then 0xB → occ_o=2 and in_ready_o=0. Release out_ready_i → 0xA then 0xB in order, occ_o returns to 0.
- Flush while FULL: CLEAR_ON_FLUSH=1, holding 0xA and 0xB, with flush_i and in_valid_i=1 (data 0xC) in the same cycle → next cycle out_valid_o=0, out_data_o=0, occ_o=0. 0xC never appears.
- Flush while BUSY: CLEAR_ON_FLUSH=0, holding 0x5 → out_valid_o=0 next cycle, out_data_o still 0x5, no beat delivered.
- SKID=0: with out_valid_o=1 and out_ready_i=0 → in_ready_o=0 in the same cycle. Raise out_ready_i with in_valid_i=1 (data 0x7) → in_ready_o=1 combinationally, 0x7 on output next cycle.
- Asynchronous reset asserted mid-cycle while FULL → out_valid_o=0, occ_o=0, out_data_o=0 immediately, without waiting for a clock edge. The first beat after release (0x9) is delivered with 1-cycle latency.
